row_fifo_serializer: RTL
========================

Name: row_fifo_serializer

Overview:
- Successor to the fixed 3-row, 9-bit row-FIFO collector in the systolic-array feed path.
- Pops one word from each of ROW parallel row FIFOs in a single read strobe and captures the words into a local buffer.
- Emits the captured words one per beat on a valid/ready stream toward the row-data FIFO writer.
- Generalised over row count, word width, FIFO read latency and emission order.
- Adds reset, backpressure, internal beat indexing and a last-beat marker.

Parameters:
- ROW, 3, number of row FIFOs (>=2).
- DATA_W, 9, word width per row.
- RD_LAT, 1, FIFO read latency in cycles from read-enable cycle to data-valid cycle (1..4).
- ORDER, 0, 0 = emit row ROW-1 first down to row 0; 1 = emit row 0 first up to row ROW-1.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_enable  input  1  permits starting a new FIFO read; does not stall emission already in progress.
- i_fifo_empty  input  ROW  per-row FIFO empty flags.
- i_data  input  ROW*DATA_W  FIFO read data; row r occupies bits [r*DATA_W +: DATA_W].
- o_read_enable  output  ROW  registered per-row pop strobe.
- o_data  output  DATA_W  current output word, registered.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts when o_valid && i_ready.
- o_last  output  1  high with the final word of a group.
- o_row_idx  output  $clog2(ROW)  row number of the word on o_data.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst=1 at an edge) forces:
  - state=IDLE;
  - o_read_enable=0, o_valid=0, o_last=0, o_busy=0;
  - o_data=0, o_row_idx=0;
  - latency counter=0, beat index=0.
- Reset dominates every other input. Reset mid-group discards the buffered words (they are lost, by design). A read strobe in flight is dropped.
- States: IDLE, READ, WAIT, EMIT.
- IDLE:
  - If i_enable=1 and i_fifo_empty==0 (all rows non-empty), go to READ.
  - If any row is empty, stay in IDLE; there are no partial reads.
- READ (exactly 1 cycle):
  - o_read_enable = all ones in this cycle only.
  - Load the latency counter with RD_LAT-1, then go to WAIT.
- WAIT:
  - While the counter is nonzero, decrement it.
  - At zero, i_data is valid this cycle. Capture all ROW words into the buffer, set beat index=0, and go to EMIT.
- Latency:
  - Condition sampled in cycle c; o_read_enable high in cycle c+1.
  - Data captured at the end of cycle c+1+RD_LAT; o_valid first high in cycle c+2+RD_LAT.
- EMIT:
  - o_valid=1.
  - o_row_idx = ROW-1-beat (ORDER=0) or beat (ORDER=1).
  - o_data = buffer[o_row_idx].
  - o_last=1 when beat==ROW-1.
  - o_data, o_row_idx and o_last are held stable while o_valid && !i_ready. No word is skipped or repeated.
  - On a handshake with beat<ROW-1: beat+1, next word presented the following cycle (one word per cycle at full throughput).
  - On a handshake with beat==ROW-1: o_valid=0 next cycle, go to IDLE.
  - No back-to-back group start: the earliest next READ is 1 cycle after IDLE is re-entered. Steady-state period is ROW+RD_LAT+2 cycles per group with i_ready=1.
- i_enable and i_fifo_empty are ignored outside IDLE. Deasserting i_enable mid-group completes the group.
- The beat index uses $clog2(ROW) bits and never exceeds ROW-1. There is no wrap past the last word.

Decomposition:
- Shared package sa_pkg holds:
  - the state enum (IDLE, READ, WAIT, EMIT);
  - a helper for index width, max(1,$clog2(ROW));
  - the ORDER encoding constants ORDER_HI_FIRST=0 and ORDER_LO_FIRST=1.
- One natural sub-module: sa_word_select, the combinational ROW-to-1 word mux indexed by o_row_idx. Reusable by other row-feed blocks.
- The FSM, counters and buffer stay in the top.

Test Plan:
- Basic order: ROW=3, DATA_W=9, RD_LAT=1, ORDER=0, i_ready=1, i_data={9'h1AA,9'h055,9'h0F0}, all non-empty from cycle 0 -> o_read_enable=3'b111 in cycle 1 only; o_data 1AA/055/0F0 in cycles 3/4/5 with o_row_idx 2/1/0; o_last only in cycle 5.
- ORDER=1, same stimulus -> o_data 0F0/055/1AA with o_row_idx 0/1/2.
- Backpressure: i_ready=0 for cycles 3-6, then 1 -> o_data=1AA held through cycle 7; 055 in cycle 8; 0F0 with o_last in cycle 9; no extra o_read_enable pulse.
- Empty gating: i_fifo_empty=3'b010 for 10 cycles, then 0 -> no o_read_enable while any bit is set; the strobe occurs 1 cycle after the flags clear.
- RD_LAT=3, ROW=4, DATA_W=16 -> the first o_valid appears exactly RD_LAT+2=5 cycles after the condition cycle; o_data equals the words sampled exactly 3 cycles after the strobe cycle, not before.
- Reset mid-EMIT: assert i_rst at the second beat -> all outputs 0 on the next cycle; after release with FIFOs non-empty, a fresh group starts from beat 0 with o_row_idx=ROW-1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array row-feed blocks.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    EMIT
  } state_e;

  localparam int ORDER_HI_FIRST = 0;
  localparam int ORDER_LO_FIRST = 1;

  function automatic int idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/sa_word_select.sv
// Combinational ROW-to-1 word multiplexer over a packed row vector.
module sa_word_select
  import sa_pkg::*;
#(
  parameter int ROW    = 3,
  parameter int DATA_W = 9
) (
  input  logic [ROW*DATA_W-1:0]  words,
  input  logic [idx_w(ROW)-1:0]  sel,
  output logic [DATA_W-1:0]      word
);

  localparam int IDX_W = idx_w(ROW);

  always_comb begin
    // NOTE: default first so out-of-range selects cannot infer a latch.
    word = '0;
    for (int r = 0; r < ROW; r++) begin
      if (sel == IDX_W'(r)) word = words[r*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/row_fifo_serializer.sv
// Pops one word from every row FIFO at once, then streams the captured
// words out one per beat with valid/ready, a row index and a last marker.
module row_fifo_serializer
  import sa_pkg::*;
#(
  parameter int ROW    = 3,
  parameter int DATA_W = 9,
  parameter int RD_LAT = 1,
  parameter int ORDER  = ORDER_HI_FIRST
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [ROW-1:0]          i_fifo_empty,
  input  logic [ROW*DATA_W-1:0]   i_data,
  output logic [ROW-1:0]          o_read_enable,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic [$clog2(ROW)-1:0]  o_row_idx,
  output logic                    o_busy
);

  localparam int IDX_W = idx_w(ROW);
  localparam int CNT_W = 2;

  state_e                state;
  logic [CNT_W-1:0]      lat_cnt;
  logic [IDX_W-1:0]      beat;
  logic [ROW*DATA_W-1:0] row_buf;
  logic [ROW*DATA_W-1:0] sel_words;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_W-1:0]     sel_word;
  logic                  capture;
  logic                  handshake;

  function automatic logic [IDX_W-1:0] row_of(input logic [IDX_W-1:0] b);
    return (ORDER == ORDER_HI_FIRST) ? IDX_W'(ROW - 1) - b : b;
  endfunction

  assign capture   = (state == WAIT) && (lat_cnt == '0);
  assign handshake = o_valid && i_ready;
  assign o_busy    = (state != IDLE);

  // The first word comes straight from the FIFO bus; later ones from the buffer.
  always_comb begin
    sel_words = row_buf;
    sel_idx   = row_of(beat + IDX_W'(1));
    if (state == WAIT) begin
      sel_words = i_data;
      sel_idx   = row_of('0);
    end
  end

  sa_word_select #(
    .ROW    (ROW),
    .DATA_W (DATA_W)
  ) u_word_select (
    .words (sel_words),
    .sel   (sel_idx),
    .word  (sel_word)
  );

  // NOTE: the word buffer carries no reset; its contents are never observed
  // until a capture has overwritten every row.
  always_ff @(posedge i_clk) begin
    if (capture) row_buf <= i_data;
  end

  // NOTE: non-blocking assignments throughout so every register sees the
  // pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_read_enable <= '0;
      o_valid       <= 1'b0;
      o_last        <= 1'b0;
      o_data        <= '0;
      o_row_idx     <= '0;
      lat_cnt       <= '0;
      beat          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable && (i_fifo_empty == '0)) begin
            state         <= READ;
            o_read_enable <= '1;
          end
        end
        READ: begin
          o_read_enable <= '0;
          lat_cnt       <= CNT_W'(RD_LAT - 1);
          state         <= WAIT;
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            beat      <= '0;
            o_data    <= sel_word;
            o_row_idx <= sel_idx;
            o_valid   <= 1'b1;
            o_last    <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (beat == IDX_W'(ROW - 1)) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              state   <= IDLE;
            end else begin
              beat      <= beat + 1'b1;
              o_data    <= sel_word;
              o_row_idx <= sel_idx;
              o_last    <= (beat == IDX_W'(ROW - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
